// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from a registered-read FIFO.
// Define FIFO_UART_PARITY_EN to add an even-parity bit after the data field.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic                  Enable_in,
    input  logic                  Fifo_Empty_in,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    output logic                  Fifo_ReadEn_out,
    output logic                  Tx_out,
    output logic                  Busy_out
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_START,
        S_DATA,
`ifdef FIFO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  tx_n, rd_n;
    logic                  bit_done;
`ifdef FIFO_UART_PARITY_EN
    logic                  par, par_n;
`endif

    assign bit_done = (timer == TMAX);
    assign Busy_out = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state           <= S_IDLE;
            timer           <= '0;
            idx             <= '0;
            shreg           <= '0;
            Tx_out          <= 1'b1;
            Fifo_ReadEn_out <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
            par             <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            idx             <= idx_n;
            shreg           <= shreg_n;
            Tx_out          <= tx_n;
            Fifo_ReadEn_out <= rd_n;
`ifdef FIFO_UART_PARITY_EN
            par             <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = Tx_out;
        rd_n    = 1'b0;
`ifdef FIFO_UART_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (Enable_in && !Fifo_Empty_in) begin
                    rd_n    = 1'b1;
                    state_n = S_POP;
                end
            end
            S_POP: begin
                state_n = S_LATCH;
            end
            // Read data is valid here, one cycle after the pop strobe.
            S_LATCH: begin
                shreg_n = Fifo_Data_in;
                tx_n    = 1'b0;
                timer_n = '0;
                idx_n   = '0;
`ifdef FIFO_UART_PARITY_EN
                par_n   = ^Fifo_Data_in;
`endif
                state_n = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                    timer_n = '0;
                    state_n = S_DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_n = '0;
                    if (idx == LAST) begin
`ifdef FIFO_UART_PARITY_EN
                        tx_n    = par;
                        state_n = S_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                        idx_n   = idx + 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`ifdef FIFO_UART_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    tx_n    = 1'b1;
                    timer_n = '0;
                    state_n = S_STOP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a registered-read FIFO model.
// Two instances: divider 4 (main) and divider 2 (minimum).
module tb_fifo_uart_tx;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       clear, enable;
    logic       empty1, empty2;
    logic [7:0] fdata1 = 8'h00;
    logic [7:0] fdata2 = 8'h00;
    logic       rd1, rd2, tx1, tx2, busy1, busy2;

    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];
    logic [4:0] wp1 = 5'd0;
    logic [4:0] rp1 = 5'd0;
    logic [4:0] wp2 = 5'd0;
    logic [4:0] rp2 = 5'd0;

    assign empty1 = (wp1 == rp1);
    assign empty2 = (wp2 == rp2);

    always @(posedge Clk) begin
        if (rd1) begin
            fdata1 <= mem1[rp1];
            rp1    <= rp1 + 5'd1;
        end
        if (rd2) begin
            fdata2 <= mem2[rp2];
            rp2    <= rp2 + 5'd1;
        end
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .Clk             (Clk),
        .Clear_in        (clear),
        .Enable_in       (enable),
        .Fifo_Empty_in   (empty1),
        .Fifo_Data_in    (fdata1),
        .Fifo_ReadEn_out (rd1),
        .Tx_out          (tx1),
        .Busy_out        (busy1)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut2 (
        .Clk             (Clk),
        .Clear_in        (clear),
        .Enable_in       (enable),
        .Fifo_Empty_in   (empty2),
        .Fifo_Data_in    (fdata2),
        .Fifo_ReadEn_out (rd2),
        .Tx_out          (tx2),
        .Busy_out        (busy2)
    );

    logic sel = 1'b0;
    logic tx_m, rd_m, busy_m;
    assign tx_m   = sel ? tx2 : tx1;
    assign rd_m   = sel ? rd2 : rd1;
    assign busy_m = sel ? busy2 : busy1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops1 = 0;
    int txlow1 = 0;
    int last_fall, stop_begin, last_len;

    always @(posedge Clk) cyc++;
    always @(negedge Clk) begin
        if (rd1) pops1++;
        if (!tx1) txlow1++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs [6];

`ifdef FIFO_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 5'd1;
    endtask

    task automatic push2(input logic [7:0] d);
        mem2[wp2] = d;
        wp2 = wp2 + 5'd1;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic par,
                             input int cpb, input string tag);
        logic [10:0] fb;
        logic        ok;
        int          n;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
`ifdef FIFO_UART_PARITY_EN
        fb[9]  = par;
        fb[10] = 1'b1;
`else
        fb[9]  = 1'b1;
        fb[10] = par;
`endif
        n = 0;
        @(negedge Clk);
        while (!rd_m && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check({tag, " pop seen"}, rd_m, 1);
        if (!rd_m) return;
        check({tag, " busy with pop"}, busy_m, 1);
        @(negedge Clk);
        check({tag, " pop width"}, rd_m, 0);
        check({tag, " tx high in pop"}, tx_m, 1);
        @(negedge Clk);
        check({tag, " start fall"}, tx_m, 0);
        last_fall = cyc;
        for (int b = 0; b < NBITS; b++) begin
            ok = 1'b1;
            for (int k = 0; k < cpb; k++) begin
                if (!(b == 0 && k == 0)) @(negedge Clk);
                if (b == NBITS - 1 && k == 0) stop_begin = cyc;
                if (tx_m !== fb[b]) ok = 1'b0;
                if (rd_m !== 1'b0) ok = 1'b0;
            end
            check($sformatf("%s bit%0d", tag, b), ok, 1);
        end
        @(negedge Clk);
        check({tag, " busy drop"}, busy_m, 0);
        last_len = cyc - last_fall;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    int p, t, sb;

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h3C, 1'b0};
        vecs[5] = '{8'h80, 1'b1};

        clear  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset tx", tx1, 1);
        check("reset rden", rd1, 0);
        check("reset busy", busy1, 0);
        check("reset tx2", tx2, 1);
        check("reset busy2", busy2, 0);
        clear = 1'b0;

        p = pops1;
        t = txlow1;
        repeat (100) @(negedge Clk);
        check("empty no pop", pops1 - p, 0);
        check("empty tx high", txlow1 - t, 0);

        for (int i = 0; i < 6; i++) begin
            push1(vecs[i].data);
            run_frame(vecs[i].data, vecs[i].par, 4,
                      $sformatf("vec%0d", i));
            check($sformatf("vec%0d len", i), last_len, NBITS * 4);
        end

        p = pops1;
        push1(8'h00);
        push1(8'hFF);
        run_frame(8'h00, 1'b0, 4, "b2b0");
        sb = stop_begin;
        run_frame(8'hFF, 1'b0, 4, "b2b1");
        check("b2b gap", last_fall - sb, 7);
        check("b2b pops", pops1 - p, 2);

        enable = 1'b0;
        push1(8'h5A);
        p = pops1;
        repeat (40) @(negedge Clk);
        check("disabled no pop", pops1 - p, 0);
        check("disabled idle", busy1, 0);
        enable = 1'b1;
        run_frame(8'h5A, 1'b0, 4, "reen");

        push1(8'h11);
        push1(8'h22);
        fork
            run_frame(8'h11, 1'b0, 4, "mid");
            begin
                repeat (15) @(negedge Clk);
                enable = 1'b0;
            end
        join
        p = pops1;
        repeat (40) @(negedge Clk);
        check("mid no pop", pops1 - p, 0);
        check("mid tx idle", tx1, 1);
        enable = 1'b1;
        run_frame(8'h22, 1'b0, 4, "drain");

        push1(8'hA5);
        push1(8'hC3);
        p = 0;
        @(negedge Clk);
        while (!rd1 && p < 60) begin
            @(negedge Clk);
            p++;
        end
        check("clr pop seen", rd1, 1);
        repeat (19) @(negedge Clk);
        check("clr bit3 low", tx1, 0);
        check("clr busy pre", busy1, 1);
        clear = 1'b1;
        @(negedge Clk);
        check("clr tx", tx1, 1);
        check("clr busy", busy1, 0);
        check("clr rden", rd1, 0);
        clear = 1'b0;
        run_frame(8'hC3, 1'b0, 4, "post");

        sel = 1'b1;
        push2(8'h3C);
        run_frame(8'h3C, 1'b0, 2, "min");
        check("min len", last_len, NBITS * 2);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the read port of the asynchronous FIFO and shifts each word out as an asynchronous UART frame: start bit, data LSB first, optional parity, one stop bit. It sits directly downstream of the FIFO and runs entirely in the FIFO's read-clock domain. It owns the FIFO read-enable and issues exactly one pop per frame. It accounts for the FIFO's one-cycle registered read latency.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each FIFO word and of the data field in the frame.
- CLKS_PER_BIT, 16, Clk cycles per serial bit; legal range is ≥ 2. The bit counter width is $clog2(CLKS_PER_BIT).

Ports:
- Clk  in  1  sole clock; the same clock as the FIFO read clock.
- Clear_in  in  1  reset, synchronous, active-high.
- Enable_in  in  1  permits new frames to start; sampled only in IDLE.
- Fifo_Empty_in  in  1  FIFO empty flag.
- Fifo_Data_in  in  DATA_WIDTH  FIFO read data, valid one cycle after a pop.
- Fifo_ReadEn_out  out  1  registered pop strobe to the FIFO.
- Tx_out  out  1  serial line; idles high.
- Busy_out  out  1  high whenever the FSM is not in IDLE.

## Operation

- Reset values: Tx_out=1, Fifo_ReadEn_out=0, Busy_out=0, state=IDLE, all counters and the shift register are 0.
- FSM states:
  - IDLE: if Enable_in & !Fifo_Empty_in, set Fifo_ReadEn_out<=1 and go to POP. Otherwise stay.
  - POP: set Fifo_ReadEn_out<=0 and go to LATCH. The FIFO captures the word at the end of this cycle.
  - LATCH: load Fifo_Data_in into the shift register, set Tx_out<=0, clear the bit timer, go to START.
  - START: hold Tx_out=0 for CLKS_PER_BIT cycles, then drive the LSB and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles; shift right and track the bit index. After bit DATA_WIDTH-1, go to PARITY if enabled, otherwise to STOP with Tx_out<=1.
  - PARITY: hold the parity bit CLKS_PER_BIT cycles, then go to STOP with Tx_out<=1.
  - STOP: hold Tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Exactly one Fifo_ReadEn_out pulse per frame, always exactly one cycle wide. Fifo_ReadEn_out is never asserted while Fifo_Empty_in=1 in IDLE.
- Enable_in going low mid-frame has no effect; the current frame completes and no new pop is issued.
- Clear_in has priority over everything. On the next edge every output returns to its reset value and any in-flight byte is discarded. A pop already issued is not replayed.
- Fifo_Empty_in and Fifo_Data_in are ignored outside IDLE and LATCH respectively.

## Timing

- Pop to start bit: Fifo_ReadEn_out rises on edge E. Tx_out falls on edge E+2.
- Frame length, measured from the Tx_out fall to the first IDLE cycle: (2+DATA_WIDTH+P)·CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames with the FIFO non-empty: Tx_out is high for CLKS_PER_BIT+3 cycles between data frames. That is the stop bit plus the IDLE, POP and LATCH cycles.
- Busy_out rises on the same edge as Fifo_ReadEn_out. It falls on the edge that enters IDLE.

## Configuration

- FIFO_UART_PARITY_EN defined: the PARITY state is compiled in. The parity bit is even parity, i.e. the XOR of all DATA_WIDTH data bits, computed at LATCH. The frame is DATA_WIDTH+3 bits.
- Macro undefined: there is no PARITY state and no parity logic. DATA goes directly to STOP and the frame is DATA_WIDTH+2 bits.

## Test plan

- Single byte: CLKS_PER_BIT=4, no parity, FIFO holds 0xA5.
  - Fifo_ReadEn_out pulses for 1 cycle.
  - Tx_out falls 2 edges later.
  - Tx_out then carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Busy_out then drops.
- Back-to-back: FIFO holds 0x00 then 0xFF, CLKS_PER_BIT=4.
  - Two pops occur.
  - The high gap between the frames is 7 cycles.
  - Stream 2 carries eight 1s.
- Empty and disable gating:
  - With Fifo_Empty_in=1 for 100 cycles: no pop and Tx_out=1 throughout.
  - With Enable_in=0 and the FIFO non-empty: no pop.
  - Deasserting Enable_in mid-frame: the frame completes and no further pop occurs.
- Parity build (FIFO_UART_PARITY_EN):
  - 0xA5 gives parity bit 0, frame 11 bits × CLKS_PER_BIT.
  - 0x01 gives parity bit 1.
- Clear mid-frame: assert Clear_in during DATA bit 3.
  - Next edge: Tx_out=1, Busy_out=0, Fifo_ReadEn_out=0.
  - After release with the FIFO non-empty, a fresh pop occurs and a full frame follows.
- Minimum divider: CLKS_PER_BIT=2, 0x3C gives a correct 20-cycle frame with each bit 2 cycles.
